// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the instruction-type units: branch funct3
// encodings, the sequential PC increment and the funct3 field position.
package riscv_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } b_func;

   localparam int unsigned PC_STEP   = 4;
   localparam int unsigned FUNCT3_HI = 14;
   localparam int unsigned FUNCT3_LO = 12;

   // Extract the funct3 field from a raw instruction word.
   function automatic logic [2:0] get_funct3(input logic [31:0] instr);
      return instr[FUNCT3_HI:FUNCT3_LO];
   endfunction

endpackage

// File: rtl/instr_io.sv
// Shared instruction-unit bus. Each instruction-type unit attaches through
// its own modport; the branch unit uses B_type_io_ports.
interface Instr_IO #(
   parameter int XLEN = 32
) (
   input logic clk
);
   logic                   reset;
   logic        [31:0]     idata;
   logic        [XLEN-1:0] iaddr;
   logic signed [XLEN-1:0] imm;
   logic signed [XLEN-1:0] rv1;
   logic signed [XLEN-1:0] rv2;
   logic        [XLEN-1:0] iaddr_val;
   logic                   br_taken;
   logic                   br_taken_q;
   logic                   misalign_q;
   logic                   illegal_q;

   modport B_type_io_ports (
      input  clk,
      input  reset,
      input  idata,
      input  iaddr,
      input  imm,
      input  rv1,
      input  rv2,
      output iaddr_val,
      output br_taken,
      output br_taken_q,
      output misalign_q,
      output illegal_q
   );
endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluator: decodes B-type funct3 and compares rs1/rs2
// signed or unsigned. Reserved encodings are never taken and flag illegal.
module branch_cmp
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic signed [XLEN-1:0] rv1,
   input  logic signed [XLEN-1:0] rv2,
   input  logic        [2:0]      funct3,
   output logic                   taken,
   output logic                   illegal
);

   b_func op;
   logic  eq;
   logic  lt_s;
   logic  lt_u;

   assign op   = b_func'(funct3);
   assign eq   = (rv1 == rv2);
   assign lt_s = (rv1 < rv2);
   assign lt_u = ($unsigned(rv1) < $unsigned(rv2));

   // Select the comparison requested by funct3; 010/011 fall to the default.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (op)
         BEQ:     taken = eq;
         BNE:     taken = ~eq;
         BLT:     taken = lt_s;
         BGE:     taken = ~lt_s;
         BLTU:    taken = lt_u;
         BGEU:    taken = ~lt_u;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/b_type.sv
// Branch-resolution unit for the single-cycle core. Produces the next PC
// combinationally and registers taken/misaligned/illegal status for the
// trap logic. The target is never alignment-masked; misalignment is only
// reported.
module b_type
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   Instr_IO.B_type_io_ports io
);

   logic [XLEN-1:0] target;
   logic [XLEN-1:0] seq_pc;
   logic            taken;
   logic            illegal;
   logic            misalign;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .rv1     (io.rv1),
      .rv2     (io.rv2),
      .funct3  (get_funct3(io.idata)),
      .taken   (taken),
      .illegal (illegal)
   );

   // Both adds wrap modulo 2^XLEN; imm is already sign-extended so a plain
   // add gives the correct backward/forward target.
   assign target   = io.iaddr + $unsigned(io.imm);
   assign seq_pc   = io.iaddr + XLEN'(PC_STEP);
   assign misalign = taken & (target[1:0] != 2'b00);

   assign io.br_taken  = taken;
   assign io.iaddr_val = taken ? target : seq_pc;

   // Status flags: cleared asynchronously while reset is low, otherwise
   // capture the live combinational values every cycle.
   always_ff @(posedge io.clk or negedge io.reset) begin
      if (!io.reset) begin
         io.br_taken_q <= 1'b0;
         io.misalign_q <= 1'b0;
         io.illegal_q  <= 1'b0;
      end else begin
         io.br_taken_q <= taken;
         io.misalign_q <= misalign;
         io.illegal_q  <= illegal;
      end
   end

endmodule

// File: tb/tb_b_type.sv
// Self-checking bench for the branch-resolution unit.
module tb_b_type;

   logic clk;
   int   vectors;
   int   miscompares;

   Instr_IO #(.XLEN(32)) bus (.clk(clk));

   b_type #(.XLEN(32)) dut (
      .io (bus.B_type_io_ports)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   // Reference: branch rule evaluated with 64-bit integer arithmetic.
   function automatic void ref_branch(input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] pc, input logic [31:0] off,
                                      output logic tk, output logic ill,
                                      output logic [31:0] npc, output logic mis);
      longint sa, sb, ua, ub, sum;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ill = (f3 == 3'b010) || (f3 == 3'b011);
      case (f3)
         3'b000:  tk = (ua == ub);
         3'b001:  tk = (ua != ub);
         3'b100:  tk = (sa < sb);
         3'b101:  tk = (sa >= sb);
         3'b110:  tk = (ua < ub);
         3'b111:  tk = (ua >= ub);
         default: tk = 1'b0;
      endcase
      if (tk) sum = longint'({32'b0, pc}) + longint'({32'b0, off});
      else    sum = longint'({32'b0, pc}) + 4;
      npc = sum[31:0];
      mis = tk && (sum % 4 != 0);
   endfunction

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off);
      bus.idata = {17'h0, f3, 5'h0, 7'b1100011};
      bus.rv1   = a;
      bus.rv2   = b;
      bus.iaddr = pc;
      bus.imm   = off;
   endtask

   task automatic test_reset();
      bus.reset = 1'b0;
      drive(3'b000, 32'd10, 32'd10, 32'h0, 32'hFF);
      #3;
      vectors++;
      if (bus.br_taken_q !== 1'b0) begin
         miscompares++; $display("FAIL reset_br_taken_q: got %b, want 0", bus.br_taken_q);
      end
      vectors++;
      if (bus.misalign_q !== 1'b0) begin
         miscompares++; $display("FAIL reset_misalign_q: got %b, want 0", bus.misalign_q);
      end
      vectors++;
      if (bus.illegal_q !== 1'b0) begin
         miscompares++; $display("FAIL reset_illegal_q: got %b, want 0", bus.illegal_q);
      end
      vectors++;
      if (bus.iaddr_val !== 32'h000000FF) begin
         miscompares++; $display("FAIL reset_comb_iaddr_val: got %h, want 000000ff", bus.iaddr_val);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.br_taken_q !== 1'b0) begin
         miscompares++; $display("FAIL reset_hold_br_taken_q: got %b, want 0", bus.br_taken_q);
      end
      @(negedge clk);
      bus.reset = 1'b1;
   endtask

   task automatic test_branch_table();
      vec_t tbl[14];
      tbl[0]  = '{3'b000, 32'd10, 32'd10, 32'h000000FF};
      tbl[1]  = '{3'b000, 32'd5,  32'd10, 32'h00000004};
      tbl[2]  = '{3'b001, 32'd10, 32'd10, 32'h00000004};
      tbl[3]  = '{3'b001, 32'd5,  32'd10, 32'h000000FF};
      tbl[4]  = '{3'b100, 32'd10, 32'd15, 32'h000000FF};
      tbl[5]  = '{3'b100, 32'd10, -32'sd15, 32'h00000004};
      tbl[6]  = '{3'b101, 32'd10, -32'sd15, 32'h000000FF};
      tbl[7]  = '{3'b101, 32'd10, 32'd15, 32'h00000004};
      tbl[8]  = '{3'b111, 32'd10, 32'd5,  32'h000000FF};
      tbl[9]  = '{3'b110, 32'd10, 32'd5,  32'h00000004};
      tbl[10] = '{3'b110, 32'hFFFFFFFF, 32'd1, 32'h00000004};
      tbl[11] = '{3'b100, 32'hFFFFFFFF, 32'd1, 32'h000000FF};
      tbl[12] = '{3'b010, 32'd10, 32'd10, 32'h00000004};
      tbl[13] = '{3'b011, 32'd10, 32'd5,  32'h00000004};
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].f3, tbl[i].a, tbl[i].b, 32'h0, 32'hFF);
         #1;
         vectors++;
         if (bus.iaddr_val !== tbl[i].exp) begin
            miscompares++;
            $display("FAIL table_iaddr_val[%0d] f3=%b: got %h, want %h", i, tbl[i].f3, bus.iaddr_val, tbl[i].exp);
         end
         vectors++;
         if (bus.br_taken !== (tbl[i].exp == 32'hFF)) begin
            miscompares++;
            $display("FAIL table_br_taken[%0d]: got %b, want %b", i, bus.br_taken, tbl[i].exp == 32'hFF);
         end
      end
   endtask

   task automatic test_wrap();
      drive(3'b001, 32'd7, 32'd7, 32'hFFFFFFFC, 32'h100);
      #1;
      vectors++;
      if (bus.iaddr_val !== 32'h00000000) begin
         miscompares++; $display("FAIL wrap_seq: got %h, want 00000000", bus.iaddr_val);
      end
      drive(3'b000, 32'd7, 32'd7, 32'hFFFFFFF0, 32'h20);
      #1;
      vectors++;
      if (bus.iaddr_val !== 32'h00000010) begin
         miscompares++; $display("FAIL wrap_target: got %h, want 00000010", bus.iaddr_val);
      end
      drive(3'b000, 32'd7, 32'd7, 32'h00001000, 32'hFFFFFFF8);
      #1;
      vectors++;
      if (bus.iaddr_val !== 32'h00000FF8) begin
         miscompares++; $display("FAIL backward_target: got %h, want 00000ff8", bus.iaddr_val);
      end
   endtask

   task automatic test_registers();
      @(negedge clk);
      drive(3'b000, 32'd10, 32'd10, 32'h0, 32'hFF);
      @(posedge clk); #1;
      vectors++;
      if (bus.br_taken_q !== 1'b1) begin
         miscompares++; $display("FAIL reg_br_taken_q: got %b, want 1", bus.br_taken_q);
      end
      vectors++;
      if (bus.misalign_q !== 1'b1) begin
         miscompares++; $display("FAIL reg_misalign_q: got %b, want 1", bus.misalign_q);
      end
      vectors++;
      if (bus.illegal_q !== 1'b0) begin
         miscompares++; $display("FAIL reg_illegal_q_clear: got %b, want 0", bus.illegal_q);
      end
      drive(3'b010, 32'd10, 32'd10, 32'h40, 32'hFF);
      #1;
      vectors++;
      if (bus.illegal_q !== 1'b0) begin
         miscompares++; $display("FAIL reg_illegal_latency: got %b, want 0 before edge", bus.illegal_q);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.illegal_q !== 1'b1) begin
         miscompares++; $display("FAIL reg_illegal_q: got %b, want 1", bus.illegal_q);
      end
      vectors++;
      if (bus.br_taken_q !== 1'b0) begin
         miscompares++; $display("FAIL reg_illegal_br_taken_q: got %b, want 0", bus.br_taken_q);
      end
      vectors++;
      if (bus.iaddr_val !== 32'h44) begin
         miscompares++; $display("FAIL illegal_iaddr_val: got %h, want 00000044", bus.iaddr_val);
      end
   endtask

   task automatic test_reset_mid();
      drive(3'b001, 32'd1, 32'd2, 32'h0, 32'h6);
      @(posedge clk); #2;
      bus.reset = 1'b0;
      #1;
      vectors++;
      if ({bus.br_taken_q, bus.misalign_q, bus.illegal_q} !== 3'b000) begin
         miscompares++;
         $display("FAIL midreset_flags: got %b, want 000", {bus.br_taken_q, bus.misalign_q, bus.illegal_q});
      end
      bus.iaddr = 32'h100;
      #1;
      vectors++;
      if (bus.iaddr_val !== 32'h106) begin
         miscompares++; $display("FAIL midreset_comb: got %h, want 00000106", bus.iaddr_val);
      end
      @(negedge clk);
      bus.reset = 1'b1;
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b, pc, off, npc;
      logic        tk, ill, mis;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ (32'h1 << $urandom_range(0, 31));
            2:       b = 32'($urandom_range(0, 20)) - 32'd10;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
         pc  = $urandom & 32'hFFFFFFFC;
         off = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'hFFFFFFFE);
         drive(f3, a, b, pc, off);
         ref_branch(f3, a, b, pc, off, tk, ill, npc, mis);
         #1;
         vectors++;
         if (bus.iaddr_val !== npc || bus.br_taken !== tk) begin
            miscompares++;
            $display("FAIL rand_comb[%0d] f3=%b: got pc=%h tk=%b, want pc=%h tk=%b", i, f3, bus.iaddr_val, bus.br_taken, npc, tk);
         end
         @(posedge clk); #1;
         vectors++;
         if ({bus.br_taken_q, bus.misalign_q, bus.illegal_q} !== {tk, mis, ill}) begin
            miscompares++;
            $display("FAIL rand_regs[%0d] f3=%b: got %b, want %b", i, f3, {bus.br_taken_q, bus.misalign_q, bus.illegal_q}, {tk, mis, ill});
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_branch_table();
      test_wrap();
      test_registers();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
